// File: rtl/cnn_mac_pkg.sv
// Shared types and default widths for the cnn_mac_seq dot-product sequencer.
package cnn_mac_pkg;

    localparam int unsigned DIN0_W       = 14;
    localparam int unsigned DIN1_W       = 9;
    localparam int unsigned PROD_W       = 24;
    localparam int unsigned ACC_W        = 32;
    localparam int unsigned LEN_W        = 10;
    localparam int unsigned DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/cnn_mac_seq_mul.sv
// Registered signed multiplier with a valid bit travelling alongside the product.
module cnn_mac_seq_mul #(
    parameter int unsigned DIN0_W = 14,
    parameter int unsigned DIN1_W = 9,
    parameter int unsigned PROD_W = 24
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              in_vld,
    input  logic [DIN0_W-1:0] a,
    input  logic [DIN1_W-1:0] b,
    output logic              out_vld,
    output logic [PROD_W-1:0] prod
);

    logic signed [PROD_W-1:0] a_ext, b_ext;
    logic signed [PROD_W-1:0] prod_d, prod_q;
    logic                     vld_d, vld_q;

    // Operands widened to the product width first so the multiply is exact.
    always_comb begin
        a_ext  = {{(PROD_W-DIN0_W){a[DIN0_W-1]}}, a};
        b_ext  = {{(PROD_W-DIN1_W){b[DIN1_W-1]}}, b};
        vld_d  = in_vld;
        prod_d = prod_q;
        if (in_vld) begin
            prod_d = a_ext * b_ext;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q  <= 1'b0;
            prod_q <= '0;
        end else begin
            vld_q  <= vld_d;
            prod_q <= prod_d;
        end
    end

    assign out_vld = vld_q;
    assign prod    = prod_q;

endmodule

// File: rtl/cnn_mac_seq.sv
// Dot-product sequencer: streams len feature/weight pairs through one multiplier
// and accumulates onto a bias, reporting via an ap_start/ap_done block handshake.
module cnn_mac_seq #(
    parameter int unsigned DIN0_W = cnn_mac_pkg::DIN0_W,
    parameter int unsigned DIN1_W = cnn_mac_pkg::DIN1_W,
    parameter int unsigned PROD_W = cnn_mac_pkg::PROD_W,
    parameter int unsigned ACC_W  = cnn_mac_pkg::ACC_W,
    parameter int unsigned LEN_W  = cnn_mac_pkg::LEN_W
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [LEN_W-1:0]  len,
    input  logic [ACC_W-1:0]  bias,
    output logic [LEN_W-1:0]  x_address0,
    output logic              x_ce0,
    input  logic [DIN0_W-1:0] x_q0,
    output logic [LEN_W-1:0]  w_address0,
    output logic              w_ce0,
    input  logic [DIN1_W-1:0] w_q0,
    output logic [ACC_W-1:0]  acc_out
);

    import cnn_mac_pkg::*;

    localparam int unsigned DRAIN_W = 2;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [ACC_W-1:0]    acc_out_q, acc_out_d;
    logic                ce_q, ce_d;
    logic                rd_vld_q, rd_vld_d;
    logic                done_q, done_d;
    logic                idle_q, idle_d;
    logic                mul_vld;
    logic [PROD_W-1:0]   mul_prod;
    logic                last_issue_c;
    logic                drain_end_c;

    assign last_issue_c = (cnt_q == len_q - LEN_W'(1));
    assign drain_end_c  = (drain_q == DRAIN_W'(DRAIN_CYCLES - 1));

    cnn_mac_seq_mul #(
        .DIN0_W (DIN0_W),
        .DIN1_W (DIN1_W),
        .PROD_W (PROD_W)
    ) u_mul (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .in_vld   (rd_vld_q),
        .a        (x_q0),
        .b        (w_q0),
        .out_vld  (mul_vld),
        .prod     (mul_prod)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ap_start) state_d = (len == '0) ? DONE : RUN;
            RUN:     if (last_issue_c) state_d = DRAIN;
            DRAIN:   if (drain_end_c) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        len_d     = len_q;
        cnt_d     = cnt_q;
        drain_d   = '0;
        acc_d     = acc_q;
        acc_out_d = acc_out_q;
        rd_vld_d  = ce_q;
        if (mul_vld) begin
            acc_d = acc_q + {{(ACC_W-PROD_W){mul_prod[PROD_W-1]}}, mul_prod};
        end
        case (state_q)
            IDLE: begin
                if (ap_start) begin
                    len_d = len;
                    cnt_d = '0;
                    acc_d = bias;
                end
            end
            RUN:     cnt_d = last_issue_c ? '0 : cnt_q + LEN_W'(1);
            DRAIN:   drain_d = drain_q + DRAIN_W'(1);
            default: ;
        endcase
        ce_d   = (state_d == RUN);
        done_d = (state_d == DONE);
        idle_d = (state_d == IDLE);
        // Last product lands on the same edge that enters DONE, so forward acc_d.
        if (state_d == DONE) begin
            acc_out_d = acc_d;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            len_q     <= '0;
            cnt_q     <= '0;
            drain_q   <= '0;
            acc_q     <= '0;
            acc_out_q <= '0;
            ce_q      <= 1'b0;
            rd_vld_q  <= 1'b0;
            done_q    <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            acc_q     <= acc_d;
            acc_out_q <= acc_out_d;
            ce_q      <= ce_d;
            rd_vld_q  <= rd_vld_d;
            done_q    <= done_d;
            idle_q    <= idle_d;
        end
    end

    assign ap_done    = done_q;
    assign ap_ready   = done_q;
    assign ap_idle    = idle_q;
    assign x_ce0      = ce_q;
    assign w_ce0      = ce_q;
    assign x_address0 = cnt_q;
    assign w_address0 = cnt_q;
    assign acc_out    = acc_out_q;

endmodule

// File: tb/tb_cnn_mac_seq.sv
// Directed-vector bench for cnn_mac_seq with behavioural feature/weight ROMs.
module tb_cnn_mac_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [9:0]  len;
    logic [31:0] bias;
    logic [9:0]  x_address0, w_address0;
    logic        x_ce0, w_ce0;
    logic [13:0] x_q0;
    logic [8:0]  w_q0;
    logic [31:0] acc_out;

    logic [13:0] xmem [0:1023];
    logic [8:0]  wmem [0:1023];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int t0    = 0;
    int w_ce_n, addr_mis;
    int          done_at [$];
    logic [31:0] done_val[$];
    int          ce_at   [$];
    logic [9:0]  ce_addr [$];

    cnn_mac_seq dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .ap_start   (ap_start),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .len        (len),
        .bias       (bias),
        .x_address0 (x_address0),
        .x_ce0      (x_ce0),
        .x_q0       (x_q0),
        .w_address0 (w_address0),
        .w_ce0      (w_ce0),
        .w_q0       (w_q0),
        .acc_out    (acc_out)
    );

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // One-cycle-latency single-port ROMs
    always @(posedge ap_clk) begin
        if (x_ce0) x_q0 <= xmem[x_address0];
        if (w_ce0) w_q0 <= wmem[w_address0];
    end

    always @(negedge ap_clk) begin
        if (ap_done) begin
            done_at.push_back(cyc);
            done_val.push_back(acc_out);
        end
        if (x_ce0) begin
            ce_at.push_back(cyc);
            ce_addr.push_back(x_address0);
        end
        if (w_ce0) w_ce_n++;
        if (w_ce0 !== x_ce0 || (x_ce0 && w_address0 !== x_address0)) addr_mis++;
    end

    // Start a run; returns at the falling edge of cycle 1 with ap_start low.
    task automatic kick(input logic [9:0] l, input logic [31:0] b);
        @(negedge ap_clk);
        done_at.delete(); done_val.delete(); ce_at.delete(); ce_addr.delete();
        w_ce_n = 0; addr_mis = 0;
        len = l; bias = b; ap_start = 1'b1; t0 = cyc;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    task automatic test_reset;
        ap_rst_n = 1'b0; ap_start = 1'b0; len = '0; bias = '0;
        x_q0 = '0; w_q0 = '0;
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        n_cmp++; if (ap_idle !== 1'b1) begin n_err++; $display("FAIL reset_idle got=%b exp=1", ap_idle); end
        n_cmp++; if (ap_done !== 1'b0 || ap_ready !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b/%b exp=0/0", ap_done, ap_ready); end
        n_cmp++; if (x_ce0 !== 1'b0 || w_ce0 !== 1'b0) begin n_err++; $display("FAIL reset_ce got=%b/%b exp=0/0", x_ce0, w_ce0); end
        n_cmp++; if (x_address0 !== 10'd0 || w_address0 !== 10'd0) begin n_err++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", x_address0, w_address0); end
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL reset_acc got=%0d exp=0", acc_out); end
    endtask

    task automatic test_basic;
        for (int i = 0; i < 4; i++) begin xmem[i] = 14'(i + 1); wmem[i] = 9'd1; end
        kick(10'd4, 32'd10);
        len = 10'd1; bias = 32'd999;
        repeat (9) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1) begin n_err++; $display("FAIL basic_done_count got=%0d exp=1", done_at.size()); end
        else begin
            n_cmp++; if (done_at[0] - t0 != 7) begin n_err++; $display("FAIL basic_done_cycle got=%0d exp=7", done_at[0] - t0); end
            n_cmp++; if (done_val[0] !== 32'd20) begin n_err++; $display("FAIL basic_acc got=%0d exp=20", done_val[0]); end
        end
        n_cmp++; if (ce_at.size() != 4) begin n_err++; $display("FAIL basic_ce_count got=%0d exp=4", ce_at.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++; if (ce_at[i] - t0 != i + 1 || ce_addr[i] !== 10'(i)) begin
                    n_err++; $display("FAIL basic_issue[%0d] got cyc=%0d addr=%0d exp cyc=%0d addr=%0d", i, ce_at[i] - t0, ce_addr[i], i + 1, i);
                end
            end
        end
        n_cmp++; if (w_ce_n != 4 || addr_mis != 0) begin n_err++; $display("FAIL basic_w_port got ce=%0d mis=%0d exp ce=4 mis=0", w_ce_n, addr_mis); end
        n_cmp++; if (acc_out !== 32'd20 || ap_done !== 1'b0 || ap_idle !== 1'b1) begin
            n_err++; $display("FAIL basic_hold got acc=%0d done=%b idle=%b exp acc=20 done=0 idle=1", acc_out, ap_done, ap_idle);
        end
    endtask

    task automatic test_extremes;
        xmem[0] = 14'h2000; wmem[0] = 9'h100;
        kick(10'd1, 32'd0);
        repeat (5) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1 || done_at[0] - t0 != 4) begin n_err++; $display("FAIL ext_neg_done got count=%0d exp count=1 at cycle 4", done_at.size()); end
        n_cmp++; if (acc_out !== 32'h0020_0000) begin n_err++; $display("FAIL ext_neg_neg got=%h exp=00200000", acc_out); end
        wmem[0] = 9'd255;
        kick(10'd1, 32'd0);
        repeat (5) @(negedge ap_clk);
        n_cmp++; if (acc_out !== 32'hFFE0_2000) begin n_err++; $display("FAIL ext_neg_pos got=%h exp=ffe02000", acc_out); end
    endtask

    task automatic test_len_zero;
        kick(10'd0, 32'hFFFF_FFFB);
        repeat (3) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1) begin n_err++; $display("FAIL len0_done_count got=%0d exp=1", done_at.size()); end
        else begin
            n_cmp++; if (done_at[0] - t0 != 1) begin n_err++; $display("FAIL len0_done_cycle got=%0d exp=1", done_at[0] - t0); end
            n_cmp++; if (done_val[0] !== 32'hFFFF_FFFB) begin n_err++; $display("FAIL len0_acc got=%h exp=fffffffb", done_val[0]); end
        end
        n_cmp++; if (ce_at.size() != 0 || w_ce_n != 0) begin n_err++; $display("FAIL len0_no_reads got x=%0d w=%0d exp 0/0", ce_at.size(), w_ce_n); end
    endtask

    task automatic test_wrap;
        xmem[0] = 14'd1; wmem[0] = 9'd1;
        kick(10'd1, 32'h7FFF_FFFF);
        repeat (5) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1 || done_val[0] !== 32'h8000_0000) begin
            n_err++; $display("FAIL wrap_acc got count=%0d acc=%h exp count=1 acc=80000000", done_at.size(), acc_out);
        end
    endtask

    task automatic test_back_to_back;
        xmem[0] = 14'd2; xmem[1] = 14'd3; wmem[0] = 9'd2; wmem[1] = 9'd3;
        @(negedge ap_clk);
        done_at.delete(); done_val.delete();
        len = 10'd2; bias = 32'd0; ap_start = 1'b1; t0 = cyc;
        for (int c = 1; c <= 14; c++) begin
            @(negedge ap_clk);
            if (c == 1) bias = 32'd100;
            if (c == 6) begin
                n_cmp++; if (ap_idle !== 1'b1) begin n_err++; $display("FAIL b2b_idle_gap got=%b exp=1", ap_idle); end
            end
            if (c == 7) begin
                n_cmp++; if (ap_idle !== 1'b0) begin n_err++; $display("FAIL b2b_restart got idle=%b exp=0", ap_idle); end
            end
            if (c == 11) ap_start = 1'b0;
        end
        n_cmp++; if (done_at.size() != 2) begin n_err++; $display("FAIL b2b_done_count got=%0d exp=2", done_at.size()); end
        else begin
            n_cmp++; if (done_at[0] - t0 != 5 || done_at[1] - t0 != 11) begin
                n_err++; $display("FAIL b2b_done_cycles got=%0d,%0d exp=5,11", done_at[0] - t0, done_at[1] - t0);
            end
            n_cmp++; if (done_val[0] !== 32'd13 || done_val[1] !== 32'd113) begin
                n_err++; $display("FAIL b2b_results got=%0d,%0d exp=13,113", done_val[0], done_val[1]);
            end
        end
    endtask

    task automatic test_reset_abort;
        for (int i = 0; i < 8; i++) begin xmem[i] = 14'd1; wmem[i] = 9'd1; end
        kick(10'd8, 32'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        n_cmp++; if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
            n_err++; $display("FAIL abort_hs got idle=%b done=%b ready=%b exp 1/0/0", ap_idle, ap_done, ap_ready);
        end
        n_cmp++; if (x_ce0 !== 1'b0 || w_ce0 !== 1'b0 || x_address0 !== 10'd0 || w_address0 !== 10'd0) begin
            n_err++; $display("FAIL abort_mem got ce=%b/%b addr=%0d/%0d exp 0/0 0/0", x_ce0, w_ce0, x_address0, w_address0);
        end
        n_cmp++; if (acc_out !== 32'd0) begin n_err++; $display("FAIL abort_acc got=%0d exp=0", acc_out); end
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (12) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 0) begin n_err++; $display("FAIL abort_no_done got=%0d exp=0", done_at.size()); end
        xmem[0] = 14'd1; xmem[1] = 14'd1; wmem[0] = 9'd5; wmem[1] = 9'd5;
        kick(10'd2, 32'd0);
        repeat (6) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1 || done_at[0] - t0 != 5 || done_val[0] !== 32'd10) begin
            n_err++; $display("FAIL abort_rerun got count=%0d acc=%0d exp count=1 cycle 5 acc=10", done_at.size(), acc_out);
        end
    endtask

    task automatic test_max_len;
        int bad;
        for (int i = 0; i < 1024; i++) begin xmem[i] = 14'd1; wmem[i] = 9'd1; end
        kick(10'd1023, 32'd0);
        repeat (1030) @(negedge ap_clk);
        n_cmp++; if (done_at.size() != 1 || done_at[0] - t0 != 1026) begin
            n_err++; $display("FAIL max_done got count=%0d exp count=1 at cycle 1026", done_at.size());
        end
        n_cmp++; if (acc_out !== 32'd1023) begin n_err++; $display("FAIL max_acc got=%0d exp=1023", acc_out); end
        bad = 0;
        foreach (ce_addr[i]) if (ce_addr[i] !== 10'(i)) bad++;
        n_cmp++; if (ce_addr.size() != 1023 || bad != 0 || addr_mis != 0) begin
            n_err++; $display("FAIL max_addr got reads=%0d bad=%0d mis=%0d exp 1023/0/0", ce_addr.size(), bad, addr_mis);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_len_zero;
        test_wrap;
        test_back_to_back;
        test_reset_abort;
        test_max_len;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
